// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit:
// FSM states, instruction field codes and datapath select values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    HALT     = 4'd10
  } state_t;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic       SRCA_RN   = 1'b0;
  localparam logic       SRCA_PC   = 1'b1;
  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic       ADR_PC  = 1'b0;
  localparam logic       ADR_ALU = 1'b1;

endpackage

// File: rtl/alu_decoder_unit.sv
// Combinational ALU decoder: maps ALUOp and the data-processing Funct field
// to the ALU operation and the flag write requests.
module alu_decoder_unit
  import ctrl_pkg::*;
(
  input  logic       alu_op,
  input  logic [5:0] funct,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w
);

  logic [3:0] cmd;
  logic       s_bit;

  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    if (alu_op) begin
      // Unsupported commands fall back to ADD and never touch the flags.
      case (cmd)
        CMD_ADD: begin alu_control = ALU_ADD; flag_w = s_bit ? 2'b11 : 2'b00; end
        CMD_SUB: begin alu_control = ALU_SUB; flag_w = s_bit ? 2'b11 : 2'b00; end
        CMD_AND: begin alu_control = ALU_AND; flag_w = s_bit ? 2'b10 : 2'b00; end
        CMD_ORR: begin alu_control = ALU_ORR; flag_w = s_bit ? 2'b10 : 2'b00; end
        default: begin alu_control = ALU_ADD; flag_w = 2'b00; end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// Moore control FSM for the multicycle ARM-subset datapath; emits unconditioned
// write requests that the downstream conditional-logic stage gates with CondEx.
//
//   state    | meaning
//   FETCH    | load IR, PC <= PC+4
//   DECODE   | read registers, ALUOut <= PC+8
//   MEMADR   | compute load/store address
//   MEMRD    | read data memory
//   MEMWB    | write loaded word to Rd
//   MEMWR    | write data memory
//   EXECUTER | ALU op, register operand
//   EXECUTEI | ALU op, immediate operand
//   ALUWB    | write ALU result to Rd
//   BRANCH   | PC <= branch target
//   HALT     | undefined op trapped, wait for reset
module multicycle_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter bit TRAP_UNDEF = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       pcs,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic       instr_done
);

  state_t state, state_next;
  logic   alu_op;
  logic   branch;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_op     = 1'b0;
    branch     = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = ADR_PC;
    ALUSrcA    = SRCA_RN;
    ALUSrcB    = SRCB_RM;
    ResultSrc  = RES_ALUOUT;
    instr_done = 1'b0;
    case (state)
      FETCH: begin
        IRWrite    = 1'b1;
        NextPC     = 1'b1;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALU;
        state_next = DECODE;
      end
      DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        case (Op)
          OP_MEM:  state_next = MEMADR;
          OP_DP:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_next = BRANCH;
          default: state_next = TRAP_UNDEF ? HALT : FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        state_next = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc     = ADR_ALU;
        state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = RES_RDATA;
        RegW       = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        AdrSrc     = ADR_ALU;
        MemW       = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      EXECUTER: begin
        alu_op     = 1'b1;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        alu_op     = 1'b1;
        ALUSrcB    = SRCB_IMM;
        state_next = ALUWB;
      end
      ALUWB: begin
        RegW       = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALU;
        branch     = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // A register write to R15 is a PC write.
  assign pcs = branch | (RegW & (Rd == 4'hF));

  alu_decoder_unit u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (Funct),
    .alu_control (ALUControl),
    .flag_w      (FlagW)
  );

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Scoreboard bench for multicycle_ctrl_unit: per-state expected output words are
// queued when an instruction is driven and compared on each falling edge.
module tb_multicycle_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;

  logic       pcs0, regw0, memw0, irw0, npc0, adr0, srca0, done0;
  logic [1:0] flagw0, srcb0, res0, aluc0;
  logic       pcs1, regw1, memw1, irw1, npc1, adr1, srca1, done1;
  logic [1:0] flagw1, srcb1, res1, aluc1;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  multicycle_ctrl_unit #(.TRAP_UNDEF(1'b0)) u_dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Rd(Rd),
    .pcs(pcs0), .RegW(regw0), .MemW(memw0), .FlagW(flagw0),
    .IRWrite(irw0), .NextPC(npc0), .AdrSrc(adr0), .ALUSrcA(srca0),
    .ALUSrcB(srcb0), .ResultSrc(res0), .ALUControl(aluc0), .instr_done(done0)
  );

  multicycle_ctrl_unit #(.TRAP_UNDEF(1'b1)) u_dut_trap (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Rd(Rd),
    .pcs(pcs1), .RegW(regw1), .MemW(memw1), .FlagW(flagw1),
    .IRWrite(irw1), .NextPC(npc1), .AdrSrc(adr1), .ALUSrcA(srca1),
    .ALUSrcB(srcb1), .ResultSrc(res1), .ALUControl(aluc1), .instr_done(done1)
  );

  logic [15:0] vec0, vec1;
  assign vec0 = {pcs0, regw0, memw0, flagw0, irw0, npc0, adr0, srca0, srcb0, res0, aluc0, done0};
  assign vec1 = {pcs1, regw1, memw1, flagw1, irw1, npc1, adr1, srca1, srcb1, res1, aluc1, done1};

  function automatic logic [15:0] pk(input logic p, input logic rw, input logic mw,
                                     input logic [1:0] fw, input logic irw, input logic npc,
                                     input logic adr, input logic sa, input logic [1:0] sb,
                                     input logic [1:0] rs, input logic [1:0] ac, input logic dn);
    return {p, rw, mw, fw, irw, npc, adr, sa, sb, rs, ac, dn};
  endfunction

  // Expected output words, field order pcs,RegW,MemW,FlagW,IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,instr_done
  localparam logic [15:0] V_FETCH  = {1'b0,1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b1,2'b10,2'b10,2'b00,1'b0};
  localparam logic [15:0] V_DECODE = {1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,2'b10,2'b10,2'b00,1'b0};
  localparam logic [15:0] V_MEMADR = {1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [15:0] V_MEMRD  = {1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [15:0] V_MEMWR  = {1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1};
  localparam logic [15:0] V_BRANCH = {1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,2'b00,1'b1};
  localparam logic [15:0] V_HALT   = 16'h0000;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    if (obs !== expv) begin
      fails++;
      $display("FAIL %s: got %04h expected %04h", tag, obs, expv);
    end
  endtask

  task automatic set_fields(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd);
    Op = op; Funct = fn; Rd = rd;
  endtask

  // Pops one expected word per cycle, checking both instances; entered and left on a falling edge.
  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() > 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      check_eq($sformatf("%s.c%0d", tag, n), vec0, e);
      check_eq($sformatf("%s.c%0d.trap", tag, n), vec1, e);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_dp(input string tag, input logic [5:0] fn, input logic [3:0] rd,
                        input logic [1:0] aluc, input logic [1:0] fw);
    set_fields(2'b00, fn, rd);
    exp_q.push_back(V_FETCH);
    exp_q.push_back(V_DECODE);
    exp_q.push_back(pk(0, 0, 0, fw, 0, 0, 0, 0, fn[5] ? 2'b01 : 2'b00, 2'b00, aluc, 0));
    exp_q.push_back(pk(rd == 4'hF, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1));
    drain(tag);
  endtask

  initial begin
    rst = 1'b1;
    set_fields(2'b00, 6'b0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset.fetch", vec0, V_FETCH);
    check_eq("reset.fetch.trap", vec1, V_FETCH);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset.decode", vec0, V_DECODE);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    run_dp("adds_r3",   6'b001001, 4'd3,  2'b00, 2'b11);
    run_dp("orr_i_r15", 6'b111000, 4'hF,  2'b11, 2'b00);
    run_dp("subs_r2",   6'b000101, 4'd2,  2'b01, 2'b11);
    run_dp("ands_i",    6'b100001, 4'd7,  2'b10, 2'b10);
    run_dp("badcmd_s",  6'b011111, 4'd1,  2'b00, 2'b00);
    run_dp("add_nos",   6'b001000, 4'd0,  2'b00, 2'b00);

    set_fields(2'b01, 6'b011001, 4'd5);
    exp_q.push_back(V_FETCH);  exp_q.push_back(V_DECODE);
    exp_q.push_back(V_MEMADR); exp_q.push_back(V_MEMRD);
    exp_q.push_back(pk(0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 1));
    drain("ldr_r5");

    set_fields(2'b01, 6'b011001, 4'hF);
    exp_q.push_back(V_FETCH);  exp_q.push_back(V_DECODE);
    exp_q.push_back(V_MEMADR); exp_q.push_back(V_MEMRD);
    exp_q.push_back(pk(1, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 1));
    drain("ldr_r15");

    set_fields(2'b01, 6'b011000, 4'hF);
    exp_q.push_back(V_FETCH);  exp_q.push_back(V_DECODE);
    exp_q.push_back(V_MEMADR); exp_q.push_back(V_MEMWR);
    drain("str");

    set_fields(2'b10, 6'b000000, 4'hF);
    exp_q.push_back(V_FETCH); exp_q.push_back(V_DECODE); exp_q.push_back(V_BRANCH);
    drain("branch");

    // Abort a load in MEMRD: the successor cycle must be FETCH with no writes.
    set_fields(2'b01, 6'b011001, 4'd4);
    exp_q.push_back(V_FETCH); exp_q.push_back(V_DECODE); exp_q.push_back(V_MEMADR);
    drain("abort_pre");
    check_eq("abort.memrd", vec0, V_MEMRD);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort.fetch", vec0, V_FETCH);
    check_eq("abort.fetch.trap", vec1, V_FETCH);
    rst = 1'b0;
    set_fields(2'b10, 6'b000000, 4'h0);
    exp_q.push_back(V_FETCH); exp_q.push_back(V_DECODE); exp_q.push_back(V_BRANCH);
    drain("after_abort");

    // Undefined op: plain instance returns to FETCH, trapping instance sticks in HALT.
    set_fields(2'b11, 6'b000000, 4'hF);
    exp_q.push_back(V_FETCH); exp_q.push_back(V_DECODE);
    drain("undef");
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("undef.loop%0d", i), vec0, (i % 2 == 0) ? V_FETCH : V_DECODE);
      check_eq($sformatf("halt.hold%0d", i), vec1, V_HALT);
      @(negedge clk);
    end
    set_fields(2'b00, 6'b001001, 4'd3);
    repeat (2) @(negedge clk);
    check_eq("halt.ignores_op", vec1, V_HALT);
    rst = 1'b1;
    @(negedge clk);
    check_eq("halt.reset", vec1, V_FETCH);
    rst = 1'b0;
    set_fields(2'b10, 6'b000000, 4'h0);
    exp_q.push_back(V_FETCH); exp_q.push_back(V_DECODE); exp_q.push_back(V_BRANCH);
    drain("after_halt");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_ctrl_unit.md
Name: multicycle_ctrl_unit

Overview:
- Multicycle ARM-subset control unit; sits directly upstream of the conditional-logic stage.
- Decodes the latched instruction fields (Op, Funct, Rd) with a Moore FSM. Produces the unconditioned write requests pcs, RegW, MemW and FlagW that the conditional-logic stage gates with CondEx.
- Also drives the datapath mux selects, IR write and PC advance for each instruction phase.

Parameters:
- TRAP_UNDEF, 0: 0 = Op=11 treated as a no-op (return to FETCH); 1 = Op=11 enters HALT until reset.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- Op  in  2  instr[27:26]: 00 data-proc, 01 memory, 10 branch, 11 undefined
- Funct  in  6  instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (data-proc) or L (memory)
- Rd  in  4  instr[15:12]
- pcs  out  1  PC-write request: Branch | (RegW & Rd==4'hF)
- RegW  out  1  register-file write request
- MemW  out  1  data-memory write request
- FlagW  out  2  [1]=NZ write request, [0]=CV write request
- IRWrite  out  1  instruction-register load
- NextPC  out  1  unconditional PC+4 write
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALU result
- ALUSrcA  out  1  0 = Rn, 1 = PC
- ALUSrcB  out  2  00 = Rm, 01 = ExtImm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = ReadData, 10 = ALU result
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- instr_done  out  1  one-cycle strobe in the last state of each instruction

Behaviour:
- Rst=1 at a rising edge loads state FETCH. All outputs are a pure function of state plus Op/Funct/Rd (Moore). After reset they are the FETCH values.
- Reset mid-instruction aborts the instruction. No write request is asserted in the reset cycle's successor, since FETCH issues none.
- Unlisted outputs are 0 in each state. ALUOp is internal.
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUOp=0 -> DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Transitions:
  - Op=01 -> MEMADR
  - Op=00 & I=0 -> EXECUTER
  - Op=00 & I=1 -> EXECUTEI
  - Op=10 -> BRANCH
  - Op=11 -> FETCH (TRAP_UNDEF=0) or HALT (TRAP_UNDEF=1)
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0 -> MEMRD if L=1, else MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00 -> MEMWB.
- MEMWB: ResultSrc=01, RegW=1, instr_done=1 -> FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemW=1, instr_done=1 -> FETCH.
- EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1, FlagW per decoder -> ALUWB.
- EXECUTEI: as EXECUTER but ALUSrcB=01 -> ALUWB.
- ALUWB: ResultSrc=00, RegW=1, instr_done=1 -> FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, internal Branch=1, instr_done=1 -> FETCH.
- HALT: all outputs 0; stays in HALT until rst.
- ALU decoder:
  - ALUOp=0 -> ALUControl=00, FlagW=00.
  - ALUOp=1: cmd 0100 ADD->00, 0010 SUB->01, 0000 AND->10, 1100 ORR->11; any other cmd -> ALUControl=00 and FlagW=00.
  - FlagW = S ? (ADD/SUB: 11; AND/ORR: 10) : 00.
- FlagW is nonzero only in EXECUTER/EXECUTEI, so flags latch at the end of the execute cycle.
- pcs asserts in BRANCH, and in MEMWB/ALUWB when Rd=15.
- Latency:
  - data-proc: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - undefined (TRAP_UNDEF=0): 2 cycles
- Op/Funct/Rd must be stable from DECODE to the terminal state; the IR is loaded only in FETCH.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, HALT
  - Op codes
  - cmd constants CMD_ADD/SUB/AND/ORR
  - ALUControl and select encodings
- One sub-module: alu_decoder_unit (combinational; ALUOp, Funct -> ALUControl, FlagW).
- State register and next-state/output logic stay in this module.

Test Plan:
- Reset: rst=1 for 2 cycles, then release. Outputs show FETCH values (IRWrite=1, NextPC=1, ALUSrcB=10, ResultSrc=10) and RegW=MemW=pcs=0; DECODE follows next cycle.
- ADDS Rd=3, register form: Op=00, Funct=6'b001001. Path FETCH→DECODE→EXECUTER(ALUControl=00, FlagW=11)→ALUWB(RegW=1, pcs=0, instr_done=1); 4 cycles.
- ORR immediate, Rd=15, no S: Op=00, Funct=6'b111000. Path goes through EXECUTEI(ALUSrcB=01, FlagW=00); in ALUWB, RegW=1 and pcs=1.
- LDR then STR: Op=01 with L=1 gives MEMADR→MEMRD(AdrSrc=1)→MEMWB(ResultSrc=01, RegW=1), 5 cycles. Op=01 with L=0 gives MEMWR with MemW=1, 4 cycles.
- Branch and undefined:
  - Op=10: BRANCH with pcs=1, ALUSrcB=01, then FETCH.
  - Op=11 with TRAP_UNDEF=0: returns to FETCH with no writes.
  - Op=11 with TRAP_UNDEF=1: stays in HALT (all outputs 0) until rst.
- Reset mid-operation: assert rst in MEMRD. The next cycle is FETCH, and MemW/RegW never assert for the aborted load.
